// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_if
// Purpose  : Instruction-memory request/response bus between the fetch
//            stage (master) and the instruction memory (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_data_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_data_i
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction fetch stage. Keeps one memory access outstanding,
//            presents instructions to IF_ID through an output register backed
//            by a one-entry skid buffer, and handles branch redirects by
//            flushing held work and discarding any abandoned response.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             hazard_i,
   input  logic             branch_i,
   input  logic [31:0]      branch_target_i,
   if_fetch_stage_if.master imem_if,
   output logic             valid_o,
   output logic [31:0]      pc_o,
   output logic [31:0]      inst_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state_q,      state_d;
   logic [31:0] fetch_pc_q,   fetch_pc_d;
   logic [31:0] drop_addr_q,  drop_addr_d;
   logic        valid_q,      valid_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] inst_q,       inst_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q,    skid_pc_d;
   logic [31:0] skid_inst_q,  skid_inst_d;

   logic        ack_live;
   logic        consume;
   logic        out_free;

   // An ack only counts while a request is actually on the bus.
   assign ack_live = imem_if.imem_ack_i & (state_q != IDLE);
   assign consume  = valid_q & ~hazard_i & ~branch_i;
   // A response may go straight to the output only if nothing older is queued.
   assign out_free = (~valid_q | consume) & ~skid_valid_q;

   // In DROP the abandoned address stays on the bus until its ack arrives.
   assign imem_if.imem_req_o  = (state_q != IDLE);
   assign imem_if.imem_addr_o = (state_q == REQ)  ? fetch_pc_q  :
                                (state_q == DROP) ? drop_addr_q : 32'h0;

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC_ALIGNED;
         drop_addr_q  <= 32'h0;
         valid_q      <= 1'b0;
         pc_q         <= 32'h0;
         inst_q       <= 32'h0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= 32'h0;
         skid_inst_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         drop_addr_q  <= drop_addr_d;
         valid_q      <= valid_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_inst_q  <= skid_inst_d;
      end
   end

   // Next state: redirect first, then drain output/skid, then accept response.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      drop_addr_d  = drop_addr_q;
      valid_d      = valid_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_inst_d  = skid_inst_q;

      if (branch_i) begin
         // Flush everything held; any same-edge response belongs to the old path.
         valid_d      = 1'b0;
         pc_d         = 32'h0;
         inst_d       = 32'h0;
         skid_valid_d = 1'b0;
         fetch_pc_d   = branch_target_i & 32'hFFFF_FFFC;
         case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (ack_live) begin
                  state_d = REQ;
               end else begin
                  // Access still in flight: keep it on the bus until it completes.
                  state_d     = DROP;
                  drop_addr_d = fetch_pc_q;
               end
            end
            DROP:    state_d = ack_live ? REQ : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         if (consume) begin
            if (skid_valid_q) begin
               valid_d      = 1'b1;
               pc_d         = skid_pc_q;
               inst_d       = skid_inst_q;
               skid_valid_d = 1'b0;
            end else begin
               valid_d = 1'b0;
               pc_d    = 32'h0;
               inst_d  = 32'h0;
            end
         end

         case (state_q)
            IDLE: begin
               if (!skid_valid_d) begin
                  state_d = REQ;
               end
            end
            REQ: begin
               if (ack_live) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  if (out_free) begin
                     valid_d = 1'b1;
                     pc_d    = fetch_pc_q;
                     inst_d  = imem_if.imem_data_i;
                     state_d = REQ;
                  end else begin
                     // Output is occupied: park in the skid and stop fetching.
                     skid_valid_d = 1'b1;
                     skid_pc_d    = fetch_pc_q;
                     skid_inst_d  = imem_if.imem_data_i;
                     state_d      = IDLE;
                  end
               end
            end
            DROP: begin
               if (ack_live) begin
                  state_d = REQ;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
